square_root_sequencer: RTL and testbench



---
 rtl/square_root_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_square_root_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_root_sequencer.sv
// -----------------------------------------------------------------------------
// square_root_sequencer
//
// Control FSM for a successive-approximation square-root datapath. A single
// rising edge on the push-button start input launches a fixed schedule of
// ITERATIONS steps. Each step is ADD -> CHECK -> (UNDO) -> HALF, and the
// datapath keeps one result bit per step.
//
// Handshake: busy is high from the LOAD cycle through the last HALF cycle.
// done rises in the first DONE cycle and stays high until the next start edge.
// done drops in that LOAD cycle.
// Each action_* output is a one-cycle pulse. At most one is high in a cycle.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   start          raw push-button request, asynchronous to clock
//   flag_greater   datapath: trial root squared exceeds the number; only
//                  looked at in CHECK
//   action_load    datapath loads number, clears root, sets step to MSB
//   action_add     datapath root <= root + step
//   action_undo    datapath root <= root - step
//   action_half    datapath step <= step >> 1
//   busy           run in progress (LOAD .. last HALF)
//   done           result valid on the datapath root
//   iteration      completed iterations in the current run
//   o_dbg_state    current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module square_root_sequencer #(
   parameter int ITERATIONS  = 8,
   parameter int COUNT_WIDTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   flag_greater,
   output logic                   action_load,
   output logic                   action_add,
   output logic                   action_undo,
   output logic                   action_half,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] iteration,
   output logic [2:0]             o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ADD   = 3'd2,
      S_CHECK = 3'd3,
      S_UNDO  = 3'd4,
      S_HALF  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] LP_LAST = COUNT_WIDTH'(ITERATIONS);
   localparam logic [COUNT_WIDTH-1:0] LP_ONE  = COUNT_WIDTH'(1);

   state_t                 r_state;
   state_t                 w_next_state;

   logic                   r_sync1;
   logic                   r_sync2;
   logic                   r_hist;
   logic                   w_start_edge;

   logic                   r_load;
   logic                   r_add;
   logic                   r_undo;
   logic                   r_half;
   logic                   r_busy;
   logic                   r_done;
   logic [COUNT_WIDTH-1:0] r_iteration;

   logic                   w_load;
   logic                   w_add;
   logic                   w_undo;
   logic                   w_half;
   logic                   w_busy;
   logic                   w_done;
   logic [COUNT_WIDTH-1:0] w_iteration;
   logic [COUNT_WIDTH-1:0] w_iter_inc;

   // ---------------------------------------------------------------------------
   // Start conditioning: two synchroniser flops, then a history flop.
   // The edge detector fires once per rising edge, so a held button gives
   // only one edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_hist  <= 1'b0;
      end else begin
         r_sync1 <= start;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   assign w_start_edge = r_sync2 & ~r_hist;
   assign w_iter_inc   = r_iteration + LP_ONE;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic. Start edges that arrive during LOAD..HALF are dropped.
   // They are not remembered.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_start_edge) w_next_state = S_LOAD;
         S_LOAD:  w_next_state = S_ADD;
         S_ADD:   w_next_state = S_CHECK;
         // flag_greater reflects the root the datapath computed on the ADD edge
         S_CHECK: w_next_state = flag_greater ? S_UNDO : S_HALF;
         S_UNDO:  w_next_state = S_HALF;
         S_HALF:  w_next_state = (w_iter_inc == LP_LAST) ? S_DONE : S_ADD;
         S_DONE:  if (w_start_edge) w_next_state = S_LOAD;
         default: w_next_state = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode from the next state. The outputs are registered below, so
   // each action is high exactly during the cycle of its own state.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_load      = (w_next_state == S_LOAD);
      w_add       = (w_next_state == S_ADD);
      w_undo      = (w_next_state == S_UNDO);
      w_half      = (w_next_state == S_HALF);
      w_done      = (w_next_state == S_DONE);
      w_busy      = (w_next_state == S_LOAD) || (w_next_state == S_ADD)  ||
                    (w_next_state == S_CHECK) || (w_next_state == S_UNDO) ||
                    (w_next_state == S_HALF);
      w_iteration = r_iteration;
      if (w_next_state == S_LOAD) begin
         w_iteration = '0;
      end else if (r_state == S_HALF) begin
         // The count advances as HALF completes. It holds ITERATIONS in DONE.
         w_iteration = w_iter_inc;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_load      <= 1'b0;
         r_add       <= 1'b0;
         r_undo      <= 1'b0;
         r_half      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_iteration <= '0;
      end else begin
         r_load      <= w_load;
         r_add       <= w_add;
         r_undo      <= w_undo;
         r_half      <= w_half;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_iteration <= w_iteration;
      end
   end

   assign action_load = r_load;
   assign action_add  = r_add;
   assign action_undo = r_undo;
   assign action_half = r_half;
   assign busy        = r_busy;
   assign done        = r_done;
   assign iteration   = r_iteration;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_square_root_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for square_root_sequencer with ITERATIONS=8.
// A small datapath model (8-bit number, root and step) produces flag_greater
// in three modes: tied 0, tied 1, or the real comparison root*root > number.
// Each launched run pushes its expected {root, latency} to exp_q.
// The entry is popped when done rises.
// -----------------------------------------------------------------------------
module tb_square_root_sequencer;

   localparam int ITER = 8;
   localparam int CW   = 4;
   localparam int W    = 16;

   logic          clock;
   logic          reset;
   logic          start;
   logic          flag_greater;
   logic          action_load;
   logic          action_add;
   logic          action_undo;
   logic          action_half;
   logic          busy;
   logic          done;
   logic [CW-1:0] iteration;
   logic [2:0]    dbg_state;

   square_root_sequencer #(
      .ITERATIONS  (ITER),
      .COUNT_WIDTH (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .flag_greater (flag_greater),
      .action_load  (action_load),
      .action_add   (action_add),
      .action_undo  (action_undo),
      .action_half  (action_half),
      .busy         (busy),
      .done         (done),
      .iteration    (iteration),
      .o_dbg_state  (dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // datapath model
   logic [1:0] tb_mode;
   logic [7:0] tb_number;
   logic [7:0] m_num;
   logic [7:0] m_root;
   logic [7:0] m_step;

   always @(posedge clock) begin
      if (action_load) begin
         m_num  <= tb_number;
         m_root <= 8'd0;
         m_step <= 8'h80;
      end else if (action_add) begin
         m_root <= m_root + m_step;
      end else if (action_undo) begin
         m_root <= m_root - m_step;
      end else if (action_half) begin
         m_step <= m_step >> 1;
      end
   end

   assign flag_greater = (tb_mode == 2'd0) ? 1'b0 :
                         (tb_mode == 2'd1) ? 1'b1 :
                         (({8'd0, m_root} * {8'd0, m_root}) > {8'd0, m_num});

   // vector table
   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] number;
      logic [7:0] exp_root;
      logic [7:0] exp_lat;
      logic [3:0] exp_undo;
   } vec_t;

   vec_t vecs [0:5];

   // scoreboard and monitor state
   logic [W-1:0] exp_q [$];
   int           tests;
   int           fails;
   int           cyc;
   int           load_cyc;
   int           n_load;
   int           n_add;
   int           n_undo;
   int           n_half;
   int           n_check;
   logic         seen_done;
   logic [3:0]   prev_act;
   logic         prev_done;
   logic [2:0]   prev_state;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: wait for the falling edge, then observe the DUT.
   task automatic tick();
      logic [3:0]   act;
      logic [W-1:0] e;
      @(negedge clock);
      cyc++;
      act = {action_load, action_add, action_undo, action_half};
      if (action_load) begin
         n_load++;
         load_cyc = cyc;
         check("done_low_in_load", done, 0);
         check("busy_in_load", busy, 1);
         check("iteration_zero_in_load", iteration, 0);
      end
      if (action_add)  n_add++;
      if (action_half) n_half++;
      if (action_undo) begin
         n_undo++;
         check("undo_follows_check", prev_state, 3);
      end
      if (act != 4'd0) begin
         check("action_onehot", $onehot(act), 1);
         check("action_not_repeated", (act != prev_act), 1);
      end
      if (done && !prev_done) begin
         seen_done = 1'b1;
         check("done_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("root_at_done", m_root, e[15:8]);
            check("latency_load_to_done", cyc - load_cyc, e[7:0]);
            check("busy_low_at_done", busy, 0);
            check("iteration_at_done", iteration, ITER);
         end
      end
      prev_act   = act;
      prev_done  = done;
      prev_state = dbg_state;
   endtask

   task automatic clear_counts();
      n_load    = 0;
      n_add     = 0;
      n_undo    = 0;
      n_half    = 0;
      n_check   = 0;
      seen_done = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      tick();
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && !seen_done; k++) tick();
      check("done_within_budget", seen_done, 1);
   endtask

   task automatic run_vector(input vec_t v);
      tb_mode   = v.mode;
      tb_number = v.number;
      clear_counts();
      exp_q.push_back({v.exp_root, v.exp_lat});
      pulse_start();
      wait_done(200);
      check("load_count", n_load, 1);
      check("add_count", n_add, ITER);
      check("undo_count", n_undo, v.exp_undo);
      check("half_count", n_half, ITER);
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      cyc        = 0;
      load_cyc   = 0;
      prev_act   = 4'd0;
      prev_done  = 1'b0;
      prev_state = 3'd0;
      clear_counts();
      tb_mode    = 2'd0;
      tb_number  = 8'd0;
      start      = 1'b0;
      reset      = 1'b0;

      //         mode   number  root    latency undo
      vecs[0] = '{2'd0, 8'd0,   8'd255, 8'd25,  4'd0};
      vecs[1] = '{2'd1, 8'd0,   8'd0,   8'd33,  4'd8};
      vecs[2] = '{2'd2, 8'd0,   8'd0,   8'd33,  4'd8};
      vecs[3] = '{2'd2, 8'd1,   8'd1,   8'd32,  4'd7};
      vecs[4] = '{2'd2, 8'd144, 8'd12,  8'd31,  4'd6};
      vecs[5] = '{2'd2, 8'd255, 8'd15,  8'd29,  4'd4};

      // Reset held while start toggles: everything stays idle.
      for (int i = 0; i < 4; i++) begin
         start = i[0];
         tick();
         check("reset_outputs_zero",
               {action_load, action_add, action_undo, action_half, busy, done, iteration}, 0);
         check("reset_state_idle", dbg_state, 0);
      end
      start = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_outputs_zero",
               {action_load, action_add, action_undo, action_half, busy, done, iteration}, 0);
      end

      // Table-driven runs
      for (int i = 0; i < 6; i++) begin
         run_vector(vecs[i]);
      end

      // Start held high for 100 cycles: exactly one run.
      tb_mode   = 2'd2;
      tb_number = 8'd144;
      clear_counts();
      exp_q.push_back({8'd12, 8'd31});
      start = 1'b1;
      repeat (100) tick();
      check("held_start_done_seen", seen_done, 1);
      check("held_start_single_load", n_load, 1);
      check("held_start_done_high", done, 1);
      start = 1'b0;
      repeat (5) tick();
      check("done_holds_after_release", done, 1);

      // Extra start pulses while busy are ignored.
      tb_mode = 2'd0;
      clear_counts();
      exp_q.push_back({8'd255, 8'd25});
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         start = 1'b1;
         repeat (2) tick();
         start = 1'b0;
         repeat (2) tick();
      end
      wait_done(100);
      check("busy_pulses_single_load", n_load, 1);
      repeat (10) tick();
      check("done_holds_in_done", done, 1);
      check("no_reload_in_done", n_load, 1);

      // Reset during the third CHECK cycle aborts the run at once.
      tb_mode   = 2'd2;
      tb_number = 8'd144;
      clear_counts();
      pulse_start();
      for (int k = 0; k < 100 && n_check < 3; k++) begin
         if (dbg_state == 3'd3) n_check++;
         if (n_check < 3) tick();
      end
      check("third_check_reached", n_check, 3);
      reset = 1'b0;
      #1;
      check("async_reset_outputs_zero",
            {action_load, action_add, action_undo, action_half, busy, done, iteration}, 0);
      check("async_reset_state_idle", dbg_state, 0);
      repeat (2) tick();
      reset = 1'b1;
      repeat (3) tick();
      check("post_abort_outputs_zero",
            {action_load, action_add, action_undo, action_half, busy, done, iteration}, 0);
      run_vector(vecs[4]);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
